pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_ras.sv | 80 ++++++++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the program-counter sequencer.
//   DEF_ADDR_W    - default pc / immediate width
//   DEF_RAS_DEPTH - default return-address stack depth
//   DEF_RESET_VEC - default pc after reset
//   pc_src_e      - selects which source drives next_pc
package pc_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_RAS_DEPTH = 4;
  localparam int DEF_RESET_VEC = 0;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    BR   = 3'd1,
    JMP  = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4
  } pc_src_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and status bundle of the pc sequencer.
//   master : drives stall / decode controls / operands, observes pc and stack status
//   slave  : the sequencer itself
interface pc_sequencer_if #(
  parameter int ADDR_W = pc_pkg::DEF_ADDR_W
);

  logic              stall;
  logic              is_jump;
  logic              is_branch;
  logic              br_taken;
  logic              is_call;
  logic              is_ret;
  logic [ADDR_W-1:0] imm_value;
  logic [ADDR_W-1:0] base_value;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output stall, is_jump, is_branch, br_taken, is_call, is_ret,
    output imm_value, base_value,
    input  pc, next_pc, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, is_jump, is_branch, br_taken, is_call, is_ret,
    input  imm_value, base_value,
    output pc, next_pc, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: LIFO return-address stack.
//   clk, rst  - clock, synchronous active-high reset (drops all entries)
//   push      - write push_data on top (ignored when full)
//   pop       - remove top entry (ignored when empty or when pushing)
//   push_data - address to push
//   pop_data  - current top entry (valid only when !empty)
//   empty     - occupancy == 0 (registered)
//   full      - occupancy == DEPTH (registered)
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              empty,
  output logic              full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // Storage is rounded up to a power of two so the slot index width
  // always matches the array size, including DEPTH = 1.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  logic [ADDR_W-1:0] mem_r [SLOTS];
  logic [CNT_W-1:0]  count_r;
  logic              empty_r;
  logic              full_r;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify requests against occupancy and derive slot indices.
  always_comb begin
    do_push_s = push & ~full_r;
    do_pop_s  = pop & ~empty_r & ~do_push_s;
    wr_idx_s  = count_r[IDX_W-1:0];
    top_idx_s = IDX_W'(count_r - CNT_W'(1));
  end

  // Occupancy counter with registered empty/full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_W'(0);
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else if (do_push_s) begin
      count_r <= count_r + CNT_W'(1);
      empty_r <= 1'b0;
      full_r  <= (count_r == CNT_W'(DEPTH - 1));
    end else if (do_pop_s) begin
      count_r <= count_r - CNT_W'(1);
      empty_r <= (count_r == CNT_W'(1));
      full_r  <= 1'b0;
    end else begin
      count_r <= count_r;
      empty_r <= empty_r;
      full_r  <= full_r;
    end
  end

  // Entry storage; contents are left as-is on reset since occupancy gates them.
  always_ff @(posedge clk) begin
    if (do_push_s && !rst) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

  assign pop_data = mem_r[top_idx_s];
  assign empty    = empty_r;
  assign full     = full_r;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with return-address stack.
//   clk, rst - clock, synchronous active-high reset
//   bus      - pc_sequencer_if.slave:
//                stall, is_jump, is_branch, br_taken, is_call, is_ret,
//                imm_value, base_value (inputs)
//                pc (registered), next_pc (combinational),
//                ras_empty, ras_full, ras_err (sticky) (outputs)
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int RESET_VEC = DEF_RESET_VEC
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  logic [ADDR_W-1:0] pc_r;
  logic              err_r;
  pc_src_e           src_s;
  logic [ADDR_W-1:0] seq_pc_s;
  logic [ADDR_W-1:0] br_pc_s;
  logic [ADDR_W-1:0] tgt_pc_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic              ras_empty_s;
  logic              ras_full_s;
  logic              push_s;
  logic              pop_s;
  logic              err_set_s;

  // Fixed priority among simultaneous controls; lower ones are dropped.
  function automatic pc_src_e select_src(
    input logic ret,
    input logic call,
    input logic jump,
    input logic branch,
    input logic taken
  );
    pc_src_e src;
    if (ret) begin
      src = RET;
    end else if (call) begin
      src = CALL;
    end else if (jump) begin
      src = JMP;
    end else if (branch && taken) begin
      src = BR;
    end else begin
      src = SEQ;
    end
    return src;
  endfunction

  // Candidate targets; a signed offset added in two's complement is the
  // same bit pattern as an unsigned add truncated to ADDR_W.
  always_comb begin
    src_s    = select_src(bus.is_ret, bus.is_call, bus.is_jump,
                          bus.is_branch, bus.br_taken);
    seq_pc_s = pc_r + ADDR_W'(1);
    br_pc_s  = seq_pc_s + bus.imm_value;
    tgt_pc_s = bus.base_value + bus.imm_value;
  end

  // Next-pc mux plus stack requests and error detection.
  always_comb begin
    next_pc_s = seq_pc_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    if (bus.stall) begin
      next_pc_s = pc_r;
    end else begin
      case (src_s)
        SEQ: next_pc_s = seq_pc_s;
        BR:  next_pc_s = br_pc_s;
        JMP: next_pc_s = tgt_pc_s;
        CALL: begin
          // The jump happens even when the return address cannot be saved.
          next_pc_s = tgt_pc_s;
          if (ras_full_s) begin
            err_set_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end
        RET: begin
          if (ras_empty_s) begin
            next_pc_s = seq_pc_s;
            err_set_s = 1'b1;
          end else begin
            next_pc_s = ras_top_s;
            pop_s     = 1'b1;
          end
        end
        default: next_pc_s = seq_pc_s;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= ADDR_W'(RESET_VEC);
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Sticky stack overflow/underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (seq_pc_s),
    .pop_data  (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full_s)
  );

  assign bus.pc        = pc_r;
  assign bus.next_pc   = next_pc_s;
  assign bus.ras_empty = ras_empty_s;
  assign bus.ras_full  = ras_full_s;
  assign bus.ras_err   = err_r;

endmodule
